// File: rtl/if_fetch_buffer.sv
// if_fetch_buffer
//   Instruction-fetch stage sitting directly behind the PC register. Issues
//   in-order fetch requests for the current PC, pulses o_pc_adv when a request
//   is accepted, and queues returned instructions with their PCs in a
//   DEPTH-entry in-order buffer drained by decode over valid/ready.
//   A flush empties the buffer and arranges for every response still in
//   flight to be dropped on arrival.
//
//   Optional feature: define IF_BUF_PERF_EN to add the o_perf_fetched and
//   o_perf_dropped wrapping event counters.

`ifndef XLEN_32b
`define XLEN_32b 1
`endif
`ifndef XLEN_64b
`define XLEN_64b 2
`endif

module if_fetch_buffer #(
    parameter  int unsigned XLEN  = `XLEN_64b,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = 1 << (XLEN + 4)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clk_en,
    input  logic [AW-1:0] i_pc,
    output logic          o_pc_adv,
    output logic          o_imem_req_valid,
    input  logic          i_imem_req_ready,
    output logic [AW-1:0] o_imem_req_addr,
    input  logic          i_imem_rsp_valid,
    input  logic [31:0]   i_imem_rsp_data,
    input  logic          i_imem_rsp_err,
    input  logic          i_flush,
    output logic          o_id_valid,
    input  logic          i_id_ready,
    output logic [31:0]   o_id_instr,
    output logic [AW-1:0] o_id_pc,
`ifdef IF_BUF_PERF_EN
    output logic [31:0]   o_perf_fetched,
    output logic [31:0]   o_perf_dropped,
`endif
    output logic          o_id_fault
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 2;

    typedef logic [PW:0]   ptr_t;
    typedef logic [CW-1:0] cnt_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam cnt_t CNT_ONE = cnt_t'(1);

    if (DEPTH < 2 || DEPTH > 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("if_fetch_buffer: DEPTH must be a power of 2 in 2..16");
    end

    // Pointers carry one extra wrap bit so full (occ == DEPTH) and empty differ.
    ptr_t rd_ptr;
    ptr_t fill_ptr;
    ptr_t alloc_ptr;
    // inflight counts every outstanding imem response, stale ones included;
    // discard counts how many of the oldest outstanding ones are stale.
    cnt_t inflight;
    cnt_t discard;

    logic [AW-1:0] pc_mem    [DEPTH];
    logic [31:0]   instr_mem [DEPTH];
    logic          fault_mem [DEPTH];

    ptr_t occ;
    logic active;
    logic req_valid;
    logic req_fire;
    logic rsp_fire;
    logic rsp_keep;
    logic rsp_drop;
    logic id_valid;
    logic id_fire;

    assign active = i_clk_en & ~i_rst;

    // Entries are allocated at request time, so occ never exceeds DEPTH and
    // its MSB alone marks the full condition.
    assign occ       = alloc_ptr - rd_ptr;
    assign req_valid = active & ~i_flush & ~occ[PW];
    assign req_fire  = req_valid & i_imem_req_ready;

    // A response is kept only when no stale responses are ahead of it and no
    // flush is redirecting the stream in the same cycle.
    assign rsp_fire  = active & i_imem_rsp_valid;
    assign rsp_keep  = rsp_fire & ~i_flush & (discard == '0);
    assign rsp_drop  = rsp_fire & (i_flush | (discard != '0));

    assign id_valid  = active & ~i_flush & (rd_ptr != fill_ptr);
    assign id_fire   = id_valid & i_id_ready;

    assign o_pc_adv         = req_fire;
    assign o_imem_req_valid = req_valid;
    assign o_imem_req_addr  = i_pc;
    assign o_id_valid       = id_valid;
    assign o_id_pc          = i_rst ? '0 : pc_mem[rd_ptr[PW-1:0]];
    assign o_id_instr       = i_rst ? '0 : instr_mem[rd_ptr[PW-1:0]];
    assign o_id_fault       = i_rst ? 1'b0 : fault_mem[rd_ptr[PW-1:0]];

    // Pointer and outstanding-response bookkeeping; flush wins over everything.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr    <= '0;
            fill_ptr  <= '0;
            alloc_ptr <= '0;
            inflight  <= '0;
            discard   <= '0;
        end else if (i_clk_en) begin
            inflight <= inflight + cnt_t'(req_fire) - cnt_t'(rsp_fire);
            if (i_flush) begin
                rd_ptr    <= '0;
                fill_ptr  <= '0;
                alloc_ptr <= '0;
                // Every response still outstanding after this cycle is stale;
                // inflight already includes the ones discard was tracking.
                discard   <= inflight - cnt_t'(rsp_fire);
            end else begin
                if (req_fire) begin
                    alloc_ptr <= alloc_ptr + PTR_ONE;
                end
                if (rsp_keep) begin
                    fill_ptr <= fill_ptr + PTR_ONE;
                end
                if (id_fire) begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                end
                if (rsp_drop) begin
                    discard <= discard - CNT_ONE;
                end
            end
        end
    end

    // Entry payload: PC captured at request, instruction and fault at response.
    // NOTE: the entry arrays are deliberately left without reset; whether an
    // entry is meaningful is decided solely by the pointers.
    always_ff @(posedge i_clk) begin
        if (req_fire) begin
            pc_mem[alloc_ptr[PW-1:0]] <= i_pc;
        end
        if (rsp_keep) begin
            instr_mem[fill_ptr[PW-1:0]] <= i_imem_rsp_data;
            fault_mem[fill_ptr[PW-1:0]] <= i_imem_rsp_err;
        end
    end

`ifdef IF_BUF_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_dropped;

    // Wrapping event counters for delivered and dropped instructions.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            perf_fetched <= '0;
            perf_dropped <= '0;
        end else if (i_clk_en) begin
            if (id_fire) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (rsp_drop) begin
                perf_dropped <= perf_dropped + 32'd1;
            end
        end
    end

    assign o_perf_fetched = perf_fetched;
    assign o_perf_dropped = perf_dropped;
`endif

endmodule

// File: tb/tb_if_fetch_buffer.sv
// tb_if_fetch_buffer
//   Directed scenarios with a scoreboard: each scenario pushes the PCs (and
//   fault flags) decode must see; a separate monitor pops and compares on
//   every o_id_valid & i_id_ready. A small imem model returns responses with
//   a configurable fixed latency, and a PC-register model follows o_pc_adv.
`timescale 1ns/1ps

module tb_if_fetch_buffer;

    localparam int AW = 64;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_clk_en;
    logic [AW-1:0] i_pc;
    logic          o_pc_adv;
    logic          o_imem_req_valid;
    logic          i_imem_req_ready;
    logic [AW-1:0] o_imem_req_addr;
    logic          i_imem_rsp_valid;
    logic [31:0]   i_imem_rsp_data;
    logic          i_imem_rsp_err;
    logic          i_flush;
    logic          o_id_valid;
    logic          i_id_ready;
    logic [31:0]   o_id_instr;
    logic [AW-1:0] o_id_pc;
    logic          o_id_fault;
`ifdef IF_BUF_PERF_EN
    logic [31:0]   o_perf_fetched;
    logic [31:0]   o_perf_dropped;
`endif

    if_fetch_buffer dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_clk_en         (i_clk_en),
        .i_pc             (i_pc),
        .o_pc_adv         (o_pc_adv),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .i_imem_rsp_err   (i_imem_rsp_err),
        .i_flush          (i_flush),
        .o_id_valid       (o_id_valid),
        .i_id_ready       (i_id_ready),
        .o_id_instr       (o_id_instr),
        .o_id_pc          (o_id_pc),
`ifdef IF_BUF_PERF_EN
        .o_perf_fetched   (o_perf_fetched),
        .o_perf_dropped   (o_perf_dropped),
`endif
        .o_id_fault       (o_id_fault)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [AW-1:0] addr;
        int            due;
    } rsp_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic          fault;
    } exp_t;

    rsp_t rsp_q[$];
    exp_t exp_q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int nfire   = 0;
    int lat     = 1;

    logic          c_rst       = 1'b1;
    logic          c_clk_en    = 1'b1;
    logic          c_flush     = 1'b0;
    logic          c_id_ready  = 1'b0;
    logic          c_req_ready = 1'b0;
    logic [AW-1:0] pc_reg      = 64'h1000;
    logic [AW-1:0] flush_tgt   = 64'h0;
    logic [AW-1:0] fault_addr  = 64'h1;

    function automatic logic [31:0] instr_of(logic [AW-1:0] a);
        return a[31:0] ^ 32'h5A5A_0013;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic exp_push(logic [AW-1:0] pc, logic fault);
        exp_t e;
        e.pc    = pc;
        e.fault = fault;
        exp_q.push_back(e);
    endtask

    // One clock cycle: apply controls and any due imem response at the
    // falling edge, then observe the handshake once outputs have settled.
    task automatic tick();
        rsp_t r;
        @(negedge i_clk);
        cyc++;
        i_rst            = c_rst;
        i_clk_en         = c_clk_en;
        i_flush          = c_flush;
        i_id_ready       = c_id_ready;
        i_imem_req_ready = c_req_ready;
        i_pc             = pc_reg;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = 32'h0;
        i_imem_rsp_err   = 1'b0;
        if (c_rst) begin
            rsp_q.delete();
        end else if (!c_clk_en) begin
            foreach (rsp_q[k]) rsp_q[k].due++;
        end else if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = instr_of(rsp_q[0].addr);
            i_imem_rsp_err   = (rsp_q[0].addr == fault_addr);
            void'(rsp_q.pop_front());
        end
        #1;
        if (o_imem_req_valid && i_imem_req_ready) begin
            r.addr = o_imem_req_addr;
            r.due  = cyc + lat;
            rsp_q.push_back(r);
            nfire++;
        end
        if (o_pc_adv) pc_reg = pc_reg + 64'd4;
        if (c_flush)  pc_reg = flush_tgt;
    endtask

    task automatic wait_drain(string name, int bound);
        int n = 0;
        while ((exp_q.size() != 0 || rsp_q.size() != 0) && n < bound) begin
            tick();
            n++;
        end
        tick();
        tick();
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Scoreboard monitor: compare every instruction handed to decode.
    initial begin
        forever begin
            @(negedge i_clk);
            #2;
            if (o_id_valid && i_id_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL id_unexpected: got pc 0x%0h expected no delivery (cycle %0d)", o_id_pc, cyc);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("id_pc",    o_id_pc,           e.pc);
                    check("id_instr", 64'(o_id_instr),   64'(instr_of(e.pc)));
                    check("id_fault", 64'(o_id_fault),   64'(e.fault));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        i_rst            = 1'b1;
        i_clk_en         = 1'b1;
        i_flush          = 1'b0;
        i_id_ready       = 1'b0;
        i_imem_req_ready = 1'b0;
        i_pc             = 64'h1000;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = 32'h0;
        i_imem_rsp_err   = 1'b0;

        // Reset state.
        tick();
        check("rst_req_valid", 64'(o_imem_req_valid), 64'd0);
        check("rst_pc_adv",    64'(o_pc_adv),         64'd0);
        check("rst_id_valid",  64'(o_id_valid),       64'd0);
        c_rst = 1'b0;
        tick();
        check("idle_req_valid", 64'(o_imem_req_valid), 64'd1);
        check("idle_pc_adv",    64'(o_pc_adv),         64'd0);
        check("idle_id_valid",  64'(o_id_valid),       64'd0);
        check("idle_req_addr",  o_imem_req_addr,       64'h1000);

        // Stream: latency 1, decode always ready, one instruction per cycle.
        lat = 1; pc_reg = 64'h1000; c_id_ready = 1'b1; c_req_ready = 1'b1;
        for (int i = 0; i < 8; i++) exp_push(64'h1000 + 64'(4 * i), 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            check("stream_pc_adv", 64'(o_pc_adv), 64'd1);
            if (i >= 2) check("stream_id_valid", 64'(o_id_valid), 64'd1);
        end
        c_req_ready = 1'b0;
        wait_drain("stream", 20);

        // Full: decode stalled, exactly DEPTH requests accepted.
        pc_reg = 64'h1000; c_id_ready = 1'b0; c_req_ready = 1'b1; nfire = 0;
        for (int i = 0; i < 4; i++) exp_push(64'h1000 + 64'(4 * i), 1'b0);
        repeat (7) tick();
        check("full_fires",     64'(nfire),            64'd4);
        check("full_req_valid", 64'(o_imem_req_valid), 64'd0);
        check("full_pc_adv",    64'(o_pc_adv),         64'd0);
        check("full_id_valid",  64'(o_id_valid),       64'd1);
        c_req_ready = 1'b0; c_id_ready = 1'b1;
        wait_drain("full", 20);

        // Flush with two requests in flight (latency 3), redirect to 0x2000.
        c_rst = 1'b1; tick(); c_rst = 1'b0;
        lat = 3; pc_reg = 64'h1000; c_req_ready = 1'b1; c_id_ready = 1'b1;
        tick(); tick();
        c_flush = 1'b1; flush_tgt = 64'h2000;
        tick();
        check("flush_req_valid", 64'(o_imem_req_valid), 64'd0);
        check("flush_pc_adv",    64'(o_pc_adv),         64'd0);
        check("flush_id_valid",  64'(o_id_valid),       64'd0);
        c_flush = 1'b0;
        exp_push(64'h2000, 1'b0);
        tick();
        check("flush_new_req", 64'(o_pc_adv), 64'd1);
        c_req_ready = 1'b0;
        wait_drain("flush_inflight", 20);
`ifdef IF_BUF_PERF_EN
        check("perf_fetched", 64'(o_perf_fetched), 64'd1);
        check("perf_dropped", 64'(o_perf_dropped), 64'd2);
`endif

        // Flush in the cycle a response arrives, one more outstanding.
        lat = 2; pc_reg = 64'h1000; c_req_ready = 1'b1;
        tick(); tick();
        c_req_ready = 1'b0; c_flush = 1'b1; flush_tgt = 64'h2000;
        tick();
        check("flush_rsp_id_valid", 64'(o_id_valid), 64'd0);
        c_flush = 1'b0;
        exp_push(64'h2000, 1'b0);
        c_req_ready = 1'b1;
        tick();
        c_req_ready = 1'b0;
        wait_drain("flush_rsp", 20);

        // Back-to-back flushes with two stale responses outstanding.
        lat = 3; pc_reg = 64'h1000; c_req_ready = 1'b1;
        tick(); tick();
        c_req_ready = 1'b0; c_flush = 1'b1; flush_tgt = 64'h2000;
        tick();
        flush_tgt = 64'h3000;
        tick();
        c_flush = 1'b0;
        exp_push(64'h3000, 1'b0);
        c_req_ready = 1'b1;
        tick();
        check("b2b_req_after_flush", 64'(o_pc_adv), 64'd1);
        c_req_ready = 1'b0;
        wait_drain("flush_b2b", 20);

        // Access fault tagged to the 0x1008 fetch only.
        lat = 1; pc_reg = 64'h1000; fault_addr = 64'h1008; c_req_ready = 1'b1;
        exp_push(64'h1000, 1'b0);
        exp_push(64'h1004, 1'b0);
        exp_push(64'h1008, 1'b1);
        exp_push(64'h100C, 1'b0);
        repeat (4) tick();
        c_req_ready = 1'b0;
        wait_drain("fault", 20);
        fault_addr = 64'h1;

        // Clock enable low freezes the buffer and masks the handshakes.
        pc_reg = 64'h4000; c_id_ready = 1'b0; c_req_ready = 1'b1;
        exp_push(64'h4000, 1'b0);
        exp_push(64'h4004, 1'b0);
        tick(); tick();
        c_req_ready = 1'b0;
        tick(); tick();
        c_clk_en = 1'b0; c_id_ready = 1'b1; c_req_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            check("clken_id_valid",  64'(o_id_valid),       64'd0);
            check("clken_req_valid", 64'(o_imem_req_valid), 64'd0);
            check("clken_pc_adv",    64'(o_pc_adv),         64'd0);
        end
        c_clk_en = 1'b1; c_req_ready = 1'b0;
        wait_drain("clk_en", 20);

        // Reset mid-stream with three entries buffered.
        pc_reg = 64'h1000; c_id_ready = 1'b0; c_req_ready = 1'b1;
        tick(); tick(); tick();
        c_req_ready = 1'b0;
        tick(); tick();
        check("pre_rst_id_valid", 64'(o_id_valid), 64'd1);
        c_rst = 1'b1;
        tick();
        check("mid_rst_id_valid",  64'(o_id_valid),       64'd0);
        check("mid_rst_req_valid", 64'(o_imem_req_valid), 64'd0);
        c_rst = 1'b0; c_id_ready = 1'b1;
        tick();
        check("post_rst_id_valid",  64'(o_id_valid),       64'd0);
        check("post_rst_req_valid", 64'(o_imem_req_valid), 64'd1);
`ifdef IF_BUF_PERF_EN
        check("post_rst_perf_fetched", 64'(o_perf_fetched), 64'd0);
        check("post_rst_perf_dropped", 64'(o_perf_dropped), 64'd0);
`endif
        repeat (3) tick();
        check("post_rst_idle", 64'(o_id_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
